// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM encoding and PC constants.
package fetch_stage_pkg;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    BUF   = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          PC_INC           = 4;

endpackage

// File: rtl/fetch_skid_buffer.sv
// Single-entry holding register for a fetched word that decode could not accept.
module fetch_skid_buffer
  import fetch_stage_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              Clk,
  input  logic              R,
  input  logic              load,
  input  logic              unload,
  input  logic              flush,
  input  logic [DATA_W-1:0] load_instr,
  input  logic [ADDR_W-1:0] load_pc4,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] pc4,
  output logic              valid
);

  // Flush wins over load so a redirect never leaves a stale word behind.
  always_ff @(posedge Clk) begin
    if (!R) begin
      instr <= '0;
      pc4   <= '0;
      valid <= 1'b0;
    end else if (flush) begin
      valid <= 1'b0;
    end else if (load) begin
      instr <= load_instr;
      pc4   <= load_pc4;
      valid <= 1'b1;
    end else if (unload) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch: PC, variable-latency memory handshake, skid buffer and IF/ID register.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              Clk,
  input  logic              R,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              imem_ready,
  input  logic              stall,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc4,
  output logic              if_valid
);

  fetch_state_t      state;
  logic [ADDR_W-1:0] pc;
  logic [ADDR_W-1:0] pc_plus4;
  logic              slot_free;
  logic              skid_load;
  logic              skid_unload;
  logic [DATA_W-1:0] skid_instr;
  logic [ADDR_W-1:0] skid_pc4;
  logic              skid_valid;

  assign pc_plus4  = pc + ADDR_W'(PC_INC);
  assign slot_free = !if_valid || !stall;
  assign pc_out    = pc;
  assign imem_addr = pc;
  assign imem_req  = R && ((state == FETCH) || (state == DROP));

  assign skid_load   = !br_taken && (state == FETCH) && imem_ready && !slot_free;
  assign skid_unload = !br_taken && (state == BUF) && !stall;

  fetch_skid_buffer #(
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .Clk        (Clk),
    .R          (R),
    .load       (skid_load),
    .unload     (skid_unload),
    .flush      (br_taken),
    .load_instr (imem_rdata),
    .load_pc4   (pc_plus4),
    .instr      (skid_instr),
    .pc4        (skid_pc4),
    .valid      (skid_valid)
  );

  // A redirect with a response still outstanding must swallow that response in DROP.
  always_ff @(posedge Clk) begin
    if (!R) begin
      state    <= FETCH;
      pc       <= RESET_PC;
      if_instr <= '0;
      if_pc4   <= '0;
      if_valid <= 1'b0;
    end else if (br_taken) begin
      pc       <= br_target;
      if_valid <= 1'b0;
      if (((state == FETCH) || (state == DROP)) && !imem_ready)
        state <= DROP;
      else
        state <= FETCH;
    end else begin
      case (state)
        FETCH: begin
          if (imem_ready) begin
            pc <= pc_plus4;
            if (slot_free) begin
              if_instr <= imem_rdata;
              if_pc4   <= pc_plus4;
              if_valid <= 1'b1;
            end else begin
              state <= BUF;
            end
          end else if (!stall) begin
            if_valid <= 1'b0;
          end
        end
        BUF: begin
          if (!stall) begin
            if_instr <= skid_instr;
            if_pc4   <= skid_pc4;
            if_valid <= skid_valid;
            state    <= FETCH;
          end
        end
        DROP: begin
          if (imem_ready)
            state <= FETCH;
        end
        default: state <= FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, slow memory, stall/skid, redirects, wrap and reset.
module tb_fetch_stage;

  logic        Clk;
  logic        R;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic        stall;
  logic        br_taken;
  logic [31:0] br_target;
  logic [31:0] pc_out;
  logic [31:0] if_instr;
  logic [31:0] if_pc4;
  logic        if_valid;

  int errors;
  int checks;

  fetch_stage dut (
    .Clk        (Clk),
    .R          (R),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ready (imem_ready),
    .stall      (stall),
    .br_taken   (br_taken),
    .br_target  (br_target),
    .pc_out     (pc_out),
    .if_instr   (if_instr),
    .if_pc4     (if_pc4),
    .if_valid   (if_valid)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Memory returns a word derived from the address it was asked for.
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic applyStimulus(input logic rdy, input logic stl,
                               input logic br, input logic [31:0] tgt);
    imem_ready = rdy;
    stall      = stl;
    br_taken   = br;
    br_target  = tgt;
    tick();
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    R          = 1'b0;
    imem_ready = 1'b0;
    stall      = 1'b0;
    br_taken   = 1'b0;
    br_target  = '0;

    tick();
    tick();
    checkOutput("rst_pc", pc_out, 32'h0);
    checkOutput("rst_req", {31'b0, imem_req}, 32'h0);
    checkOutput("rst_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("rst_instr", if_instr, 32'h0);
    checkOutput("rst_pc4", if_pc4, 32'h0);

    $display("[TB] streaming with ready every cycle");
    R = 1'b1;
    #1;
    checkOutput("rel_req", {31'b0, imem_req}, 32'h1);
    checkOutput("rel_addr", imem_addr, 32'h0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("str_valid", {31'b0, if_valid}, 32'h1);
      checkOutput("str_pc4", if_pc4, 32'(4 * (i + 1)));
      checkOutput("str_instr", if_instr, 32'(4 * i) ^ 32'hA5A5_0000);
      checkOutput("str_addr", imem_addr, 32'(4 * (i + 1)));
    end

    $display("[TB] three-cycle memory latency");
    for (int k = 0; k < 2; k++) begin
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("lat_bubble1", {31'b0, if_valid}, 32'h0);
      applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
      checkOutput("lat_bubble2", {31'b0, if_valid}, 32'h0);
      checkOutput("lat_addr_hold", imem_addr, 32'(16 + 4 * k));
      applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
      checkOutput("lat_valid", {31'b0, if_valid}, 32'h1);
      checkOutput("lat_pc4", if_pc4, 32'(20 + 4 * k));
      checkOutput("lat_instr", if_instr, 32'(16 + 4 * k) ^ 32'hA5A5_0000);
    end

    $display("[TB] stall with skid fill");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("stl_req", {31'b0, imem_req}, 32'h0);
    checkOutput("stl_pc4_hold", if_pc4, 32'd24);
    checkOutput("stl_valid_hold", {31'b0, if_valid}, 32'h1);
    for (int k = 0; k < 3; k++) begin
      applyStimulus(1'b0, 1'b1, 1'b0, 32'h0);
      checkOutput("stl_hold_pc4", if_pc4, 32'd24);
      checkOutput("stl_hold_instr", if_instr, 32'hA5A5_0014);
      checkOutput("stl_hold_req", {31'b0, imem_req}, 32'h0);
      checkOutput("stl_hold_pc", pc_out, 32'd28);
    end
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("skid_valid", {31'b0, if_valid}, 32'h1);
    checkOutput("skid_pc4", if_pc4, 32'd28);
    checkOutput("skid_instr", if_instr, 32'hA5A5_0018);
    checkOutput("skid_req", {31'b0, imem_req}, 32'h1);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("after_skid_pc4", if_pc4, 32'd32);
    checkOutput("after_skid_instr", if_instr, 32'hA5A5_001C);

    $display("[TB] redirect with request outstanding");
    applyStimulus(1'b0, 1'b0, 1'b1, 32'h100);
    checkOutput("drop_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("drop_addr", imem_addr, 32'h100);
    checkOutput("drop_req", {31'b0, imem_req}, 32'h1);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("drop_wait_valid", {31'b0, if_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("drop_discard_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("drop_next_addr", imem_addr, 32'h100);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("tgt_valid", {31'b0, if_valid}, 32'h1);
    checkOutput("tgt_pc4", if_pc4, 32'h104);
    checkOutput("tgt_instr", if_instr, 32'hA5A5_0100);

    $display("[TB] redirect during stall with full skid");
    applyStimulus(1'b1, 1'b1, 1'b0, 32'h0);
    checkOutput("fill_req", {31'b0, imem_req}, 32'h0);
    checkOutput("fill_pc4", if_pc4, 32'h104);
    applyStimulus(1'b0, 1'b1, 1'b1, 32'h200);
    checkOutput("flush_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("flush_req", {31'b0, imem_req}, 32'h1);
    checkOutput("flush_addr", imem_addr, 32'h200);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("flush_skid_empty", {31'b0, if_valid}, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("resume_pc4", if_pc4, 32'h204);
    checkOutput("resume_instr", if_instr, 32'hA5A5_0200);

    $display("[TB] PC wrap and mid-request reset");
    applyStimulus(1'b1, 1'b0, 1'b1, 32'hFFFF_FFFC);
    checkOutput("wrap_redirect_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("wrap_addr", imem_addr, 32'hFFFF_FFFC);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("wrap_valid", {31'b0, if_valid}, 32'h1);
    checkOutput("wrap_pc4", if_pc4, 32'h0);
    checkOutput("wrap_instr", if_instr, 32'h5A5A_FFFC);
    checkOutput("wrap_next_addr", imem_addr, 32'h0);
    applyStimulus(1'b1, 1'b0, 1'b0, 32'h0);
    checkOutput("post_wrap_pc4", if_pc4, 32'h4);
    applyStimulus(1'b0, 1'b0, 1'b0, 32'h0);
    checkOutput("pend_req", {31'b0, imem_req}, 32'h1);
    checkOutput("pend_addr", imem_addr, 32'h4);
    R = 1'b0;
    #1;
    checkOutput("rst_req_comb", {31'b0, imem_req}, 32'h0);
    tick();
    checkOutput("rst2_pc", pc_out, 32'h0);
    checkOutput("rst2_req", {31'b0, imem_req}, 32'h0);
    checkOutput("rst2_valid", {31'b0, if_valid}, 32'h0);
    checkOutput("rst2_pc4", if_pc4, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
